// File: rtl/mem_responder_if.sv
// Memory request/response bundle between the multicycle core and its responder.
// io_out is present only when MEM_MMIO_EN is defined.
interface mem_responder_if #(
    parameter int WIDTH  = 8,
    parameter int AWIDTH = 8
);
    logic              memread;
    logic              memwrite;
    logic [AWIDTH-1:0] adr;
    logic [WIDTH-1:0]  writedata;
    logic [WIDTH-1:0]  memdata;
    logic              mem_ready;
    logic              busy;
    logic              err;
`ifdef MEM_MMIO_EN
    logic [WIDTH-1:0]  io_out;

    modport master (
        output memread, memwrite, adr, writedata,
        input  memdata, mem_ready, busy, err, io_out
    );
    modport slave (
        input  memread, memwrite, adr, writedata,
        output memdata, mem_ready, busy, err, io_out
    );
`else
    modport master (
        output memread, memwrite, adr, writedata,
        input  memdata, mem_ready, busy, err
    );
    modport slave (
        input  memread, memwrite, adr, writedata,
        output memdata, mem_ready, busy, err
    );
`endif
endinterface

// File: rtl/mem_responder.sv
// Byte-wide memory responder with wait states and a one-cycle mem_ready pulse.
// Define MEM_MMIO_EN to map the top address onto the io_out register.
module mem_responder #(
    parameter int WIDTH       = 8,
    parameter int AWIDTH      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    state_t            state, nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              ld_cap;
    logic [AWIDTH-1:0] cap_adr;
    logic [WIDTH-1:0]  cap_data;
    logic              cap_rd, cap_wr, cap_bad;
    logic [WIDTH-1:0]  memdata_q;
    logic [WIDTH-1:0]  mem [2**AWIDTH];

    logic              req;
    logic [AWIDTH-1:0] acc_adr;
    logic              acc_rd;
    logic              load_rd;
    logic              wr_hit;
    logic [WIDTH-1:0]  rd_val;

    assign req = bus.memread | bus.memwrite;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        ld_cap  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    ld_cap = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        nxt = ACCESS;
                    end else begin
                        nxt     = WAIT;
                        cnt_nxt = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) nxt = ACCESS;
                else             cnt_nxt = cnt - 4'd1;
            end
            ACCESS:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Read data is fetched on the edge into ACCESS so it is valid with mem_ready.
    assign acc_adr = (state == IDLE) ? bus.adr : cap_adr;
    assign acc_rd  = (state == IDLE) ? (bus.memread & ~bus.memwrite) : cap_rd;
    assign load_rd = (nxt == ACCESS) & acc_rd;

`ifdef MEM_MMIO_EN
    logic [WIDTH-1:0] io_q;
    logic             rd_hit;

    assign rd_hit     = (acc_adr == {AWIDTH{1'b1}});
    assign wr_hit     = (cap_adr == {AWIDTH{1'b1}});
    assign rd_val     = rd_hit ? io_q : mem[acc_adr];
    assign bus.io_out = io_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_q <= '0;
        end else if (state == ACCESS && cap_wr && wr_hit) begin
            io_q <= cap_data;
        end
    end
`else
    assign wr_hit = 1'b0;
    assign rd_val = mem[acc_adr];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_adr   <= '0;
            cap_data  <= '0;
            cap_rd    <= 1'b0;
            cap_wr    <= 1'b0;
            cap_bad   <= 1'b0;
            memdata_q <= '0;
        end else begin
            if (ld_cap) begin
                cap_adr  <= bus.adr;
                cap_data <= bus.writedata;
                cap_rd   <= bus.memread & ~bus.memwrite;
                cap_wr   <= bus.memwrite & ~bus.memread;
                cap_bad  <= bus.memread & bus.memwrite;
            end
            if (load_rd) memdata_q <= rd_val;
        end
    end

    // Array is not reset; an aborted access never reaches ACCESS.
    always_ff @(posedge clk) begin
        if (state == ACCESS && cap_wr && !wr_hit) begin
            mem[cap_adr] <= cap_data;
        end
    end

    assign bus.memdata   = memdata_q;
    assign bus.mem_ready = (state == ACCESS);
    assign bus.busy      = (state != IDLE);
    assign bus.err       = (state == ACCESS) & cap_bad;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with one wait state,
// one with none; expected responses are queued at request time.
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder_if #(.WIDTH(8), .AWIDTH(8)) b1 ();
    mem_responder_if #(.WIDTH(8), .AWIDTH(8)) b0 ();

    mem_responder #(.WIDTH(8), .AWIDTH(8), .WAIT_CYCLES(1)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    mem_responder #(.WIDTH(8), .AWIDTH(8), .WAIT_CYCLES(0)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         due;
    } exp_t;

    exp_t       q1[$];
    exp_t       q0[$];
    logic [7:0] m1 [256];
    logic [7:0] ld1 = 8'h00;
    logic [7:0] ld0 = 8'h00;
    logic [7:0] pre [4];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (b1.mem_ready) begin
                if (q1.size() == 0) begin
                    check("b1_spurious_ready", b1.mem_ready, 0);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    check("b1_memdata", b1.memdata, e.data);
                    check("b1_err", b1.err, e.err);
                    check("b1_latency", cyc, e.due);
                    check("b1_busy_at_ready", b1.busy, 1);
                end
            end else if (b1.err) begin
                check("b1_err_without_ready", b1.err, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (b0.mem_ready) begin
                if (q0.size() == 0) begin
                    check("b0_spurious_ready", b0.mem_ready, 0);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    check("b0_memdata", b0.memdata, e.data);
                    check("b0_err", b0.err, e.err);
                    check("b0_latency", cyc, e.due);
                end
            end
        end
    end

    task automatic wait_q1();
        for (int i = 0; i < 20 && q1.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q1.size() != 0) begin
            check("b1_timeout", q1.size(), 0);
            q1.delete();
        end
    endtask

    task automatic req1(input logic rd, input logic wr,
                        input logic [7:0] a, input logic [7:0] d,
                        input logic chg);
        exp_t e;
        @(negedge clk);
        b1.memread   = rd;
        b1.memwrite  = wr;
        b1.adr       = a;
        b1.writedata = d;
        e.err = rd & wr;
        if (rd && !wr) ld1 = m1[a];
        if (wr && !rd) m1[a] = d;
        e.data = ld1;
        e.due  = cyc + 2;
        q1.push_back(e);
        @(negedge clk);
        check("b1_busy_wait", b1.busy, 1);
        b1.memread   = 1'b0;
        b1.memwrite  = 1'b0;
        b1.writedata = ~d;
        if (chg) b1.adr = a + 8'h01;
        wait_q1();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        pre = '{8'h20, 8'h02, 8'h00, 8'h80};
        b1.memread = 0; b1.memwrite = 0; b1.adr = 0; b1.writedata = 0;
        b0.memread = 0; b0.memwrite = 0; b0.adr = 0; b0.writedata = 0;
        #1;
        check("rst_memdata", b1.memdata, 0);
        check("rst_ready", b1.mem_ready, 0);
        check("rst_busy", b1.busy, 0);
        check("rst_err", b1.err, 0);
`ifdef MEM_MMIO_EN
        check("rst_io_out", b1.io_out, 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // zero-wait instance: preload, then back-to-back reads
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b0.memwrite  = 1'b1;
            b0.adr       = 8'(i);
            b0.writedata = pre[i];
            e.data = ld0; e.err = 1'b0; e.due = cyc + 1;
            q0.push_back(e);
            @(negedge clk);
        end
        b0.memwrite = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b0.memread = 1'b1;
            b0.adr     = 8'(i);
            ld0 = pre[i];
            e.data = ld0; e.err = 1'b0; e.due = cyc + 1;
            q0.push_back(e);
            @(negedge clk);
        end
        b0.memread = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("b0_queue_drained", q0.size(), 0);

        // write then read with one wait state
        req1(1'b0, 1'b1, 8'h10, 8'hA5, 1'b0);
        req1(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);

        // illegal request leaves array and memdata alone
        req1(1'b0, 1'b1, 8'h05, 8'h11, 1'b0);
        req1(1'b1, 1'b1, 8'h05, 8'h3C, 1'b0);
        req1(1'b1, 1'b0, 8'h05, 8'h00, 1'b0);

        // address change during WAIT is ignored
        req1(1'b0, 1'b1, 8'h21, 8'h44, 1'b0);
        req1(1'b0, 1'b1, 8'h22, 8'h99, 1'b0);
        req1(1'b1, 1'b0, 8'h21, 8'h00, 1'b1);
        req1(1'b1, 1'b0, 8'h22, 8'h00, 1'b0);

        // reset during WAIT aborts the write
        req1(1'b0, 1'b1, 8'h30, 8'h11, 1'b0);
        @(negedge clk);
        b1.memwrite  = 1'b1;
        b1.adr       = 8'h30;
        b1.writedata = 8'h77;
        @(negedge clk);
        b1.memwrite = 1'b0;
        rst = 1'b0;
        #1;
        check("abort_busy", b1.busy, 0);
        check("abort_ready", b1.mem_ready, 0);
        check("abort_memdata", b1.memdata, 0);
        check("abort_err", b1.err, 0);
        ld1 = 8'h00;
        ld0 = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        req1(1'b1, 1'b0, 8'h30, 8'h00, 1'b0);

        // top address: MMIO register or plain storage
        req1(1'b0, 1'b1, 8'hFF, 8'h5A, 1'b0);
`ifdef MEM_MMIO_EN
        check("io_out_write", b1.io_out, 8'h5A);
`endif
        req1(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0);
        req1(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        check("b1_queue_drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
